// File: rtl/fp_divsqrt_issue_queue.sv
// Request FIFO and single-outstanding issue control in front of the
// iterative FP div/sqrt unit, with a held valid/ready response slot.
module fp_divsqrt_issue_queue #(
  parameter int unsigned FP_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned RND_WIDTH  = 3,
  parameter int unsigned STAT_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [FP_WIDTH-1:0]   req_opa_i,
  input  logic [FP_WIDTH-1:0]   req_opb_i,
  input  logic                  req_sqrt_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  input  logic [RND_WIDTH-1:0]  req_rnd_i,
  output logic                  unit_en_o,
  output logic [FP_WIDTH-1:0]   unit_opa_o,
  output logic [FP_WIDTH-1:0]   unit_opb_o,
  output logic                  unit_sqrt_o,
  output logic [TAG_WIDTH-1:0]  unit_tag_o,
  output logic [RND_WIDTH-1:0]  unit_rnd_o,
  input  logic                  unit_ready_i,
  input  logic                  unit_valid_i,
  input  logic [FP_WIDTH-1:0]   unit_res_i,
  input  logic [STAT_WIDTH-1:0] unit_status_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [FP_WIDTH-1:0]   rsp_res_o,
  output logic [STAT_WIDTH-1:0] rsp_status_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic [FP_WIDTH-1:0]  opa;
    logic [FP_WIDTH-1:0]  opb;
    logic                 sqrt;
    logic [TAG_WIDTH-1:0] tag;
    logic [RND_WIDTH-1:0] rnd;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t head;
  entry_t wr_entry;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;

  logic [TAG_WIDTH-1:0]  infl_tag_q, infl_tag_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [FP_WIDTH-1:0]   rsp_res_q, rsp_res_d;
  logic [STAT_WIDTH-1:0] rsp_status_q, rsp_status_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;

  logic full;
  logic empty;
  logic push;
  logic issue;
  logic done;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = req_valid_i & ~full;

  // Only one op in flight, and only when the response slot will be free.
  assign issue = (state_q == IDLE) & ~empty & unit_ready_i
               & (~rsp_valid_q | rsp_ready_i);
  assign done  = (state_q == WAIT) & unit_valid_i;

  assign head     = mem_q[rptr_q];
  assign wr_entry = '{opa:  req_opa_i,
                      opb:  req_opb_i,
                      sqrt: req_sqrt_i,
                      tag:  req_tag_i,
                      rnd:  req_rnd_i};

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push)  wptr_d = wptr_q + PTR_ONE;
    if (issue) rptr_d = rptr_q + PTR_ONE;
    unique case (1'b1)
      push & ~issue: cnt_d = cnt_q + CNT_ONE;
      issue & ~push: cnt_d = cnt_q - CNT_ONE;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    infl_tag_d = infl_tag_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d    = WAIT;
          infl_tag_d = head.tag;
        end
      end
      WAIT: begin
        if (unit_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_res_d    = rsp_res_q;
    rsp_status_d = rsp_status_q;
    rsp_tag_d    = rsp_tag_q;
    if (done) begin
      rsp_valid_d  = 1'b1;
      rsp_res_d    = unit_res_i;
      rsp_status_d = unit_status_i;
      rsp_tag_d    = infl_tag_q;
    end else if (rsp_ready_i) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      infl_tag_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_res_q    <= '0;
      rsp_status_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      infl_tag_q   <= infl_tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_res_q    <= rsp_res_d;
      rsp_status_q <= rsp_status_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign req_ready_o  = ~full;
  assign unit_en_o    = issue;
  assign unit_opa_o   = head.opa;
  assign unit_opb_o   = head.opb;
  assign unit_sqrt_o  = head.sqrt;
  assign unit_tag_o   = head.tag;
  assign unit_rnd_o   = head.rnd;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_res_o    = rsp_res_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign busy_o       = ~empty | (state_q == WAIT) | rsp_valid_q;

endmodule

// File: tb/tb_fp_divsqrt_issue_queue.sv
// Randomized bench for fp_divsqrt_issue_queue against a queue-based
// reference model and a simple latency model of the div/sqrt unit.
module tb_fp_divsqrt_issue_queue;

  localparam int FW    = 32;
  localparam int TW    = 4;
  localparam int RW    = 3;
  localparam int SW    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [FW-1:0] opa;
    logic [FW-1:0] opb;
    logic          sqrt;
    logic [TW-1:0] tag;
    logic [RW-1:0] rnd;
  } req_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [FW-1:0] req_opa_i = '0;
  logic [FW-1:0] req_opb_i = '0;
  logic          req_sqrt_i = 1'b0;
  logic [TW-1:0] req_tag_i = '0;
  logic [RW-1:0] req_rnd_i = '0;
  logic          unit_en_o;
  logic [FW-1:0] unit_opa_o;
  logic [FW-1:0] unit_opb_o;
  logic          unit_sqrt_o;
  logic [TW-1:0] unit_tag_o;
  logic [RW-1:0] unit_rnd_o;
  logic          unit_ready_i = 1'b0;
  logic          unit_valid_i = 1'b0;
  logic [FW-1:0] unit_res_i = '0;
  logic [SW-1:0] unit_status_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [FW-1:0] rsp_res_o;
  logic [SW-1:0] rsp_status_o;
  logic [TW-1:0] rsp_tag_o;
  logic          busy_o;

  fp_divsqrt_issue_queue #(
    .FP_WIDTH(FW), .TAG_WIDTH(TW), .RND_WIDTH(RW),
    .STAT_WIDTH(SW), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .req_sqrt_i(req_sqrt_i), .req_tag_i(req_tag_i),
    .req_rnd_i(req_rnd_i),
    .unit_en_o(unit_en_o), .unit_opa_o(unit_opa_o),
    .unit_opb_o(unit_opb_o), .unit_sqrt_o(unit_sqrt_o),
    .unit_tag_o(unit_tag_o), .unit_rnd_o(unit_rnd_o),
    .unit_ready_i(unit_ready_i), .unit_valid_i(unit_valid_i),
    .unit_res_i(unit_res_i), .unit_status_i(unit_status_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_status_o(rsp_status_o),
    .rsp_tag_o(rsp_tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // reference model: pending requests, one in flight, one held response
  req_t          fifo_m[$];
  req_t          infl_m;
  bit            infl_v = 0;
  bit            rsp_v  = 0;
  logic [FW-1:0] rsp_res_m;
  logic [SW-1:0] rsp_st_m;
  logic [TW-1:0] rsp_tag_m;

  // unit model
  bit            u_busy = 0;
  int            u_cnt  = 0;
  logic [FW-1:0] u_res;
  logic [SW-1:0] u_st;
  int            lat_min = 1;
  int            lat_max = 4;
  int            gate_mode = 1;
  int            rsp_mode  = 1;
  bit            spur_en = 0;
  bit            force_spur = 0;

  int en_cnt = 0;
  int last_en_cyc = -1;
  int last_done_cyc = -1;
  int last_hs_cyc = -1;
  logic [FW+TW-1:0] rsp_log[$];

  task automatic check(input string name, input logic [79:0] got,
                       input logic [79:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, got, exp, cyc);
    end
  endtask

  function automatic logic [FW+SW-1:0] unit_fn(input logic [FW-1:0] a,
                                               input logic [FW-1:0] b,
                                               input logic s);
    logic [FW-1:0] r;
    logic [SW-1:0] st;
    if (!s && b == 32'h3F80_0000) r = a;
    else r = a ^ {b[15:0], b[31:16]} ^ {{(FW-1){1'b0}}, s};
    st = a[3:0] ^ b[7:4] ^ {s, 3'b000};
    return {r, st};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.opa  = $urandom;
    r.opb  = $urandom;
    r.sqrt = 1'($urandom_range(0, 1));
    r.tag  = TW'($urandom);
    r.rnd  = RW'($urandom);
    return r;
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic cycle(input bit v, input req_t r, output bit acc);
    int sz0;
    bit exp_en;
    bit dn;
    @(negedge clk_i);
    cyc++;
    req_valid_i = v;
    req_opa_i   = r.opa;
    req_opb_i   = r.opb;
    req_sqrt_i  = r.sqrt;
    req_tag_i   = r.tag;
    req_rnd_i   = r.rnd;
    unit_valid_i = 1'b0;
    if (u_busy) begin
      u_cnt--;
      if (u_cnt == 0) begin
        unit_valid_i  = 1'b1;
        unit_res_i    = u_res;
        unit_status_i = u_st;
        u_busy        = 0;
      end
    end else if (force_spur || (spur_en && $urandom_range(0, 15) == 0)) begin
      unit_valid_i  = 1'b1;
      unit_res_i    = $urandom;
      unit_status_i = SW'($urandom);
    end
    unit_ready_i = !u_busy && pick(gate_mode);
    rsp_ready_i  = pick(rsp_mode);
    #1;
    sz0    = fifo_m.size();
    exp_en = !infl_v && sz0 != 0 && unit_ready_i && (!rsp_v || rsp_ready_i);
    check("req_ready", 80'(req_ready_o), 80'(sz0 < DEPTH));
    check("unit_en", 80'(unit_en_o), 80'(exp_en));
    check("busy", 80'(busy_o), 80'(sz0 != 0 || infl_v || rsp_v));
    check("rsp_valid", 80'(rsp_valid_o), 80'(rsp_v));
    if (sz0 != 0)
      check("head", 80'({unit_opa_o, unit_opb_o, unit_sqrt_o,
                         unit_tag_o, unit_rnd_o}), 80'(fifo_m[0]));
    if (rsp_v)
      check("rsp_fields", 80'({rsp_res_o, rsp_status_o, rsp_tag_o}),
            80'({rsp_res_m, rsp_st_m, rsp_tag_m}));
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_log.push_back({rsp_res_o, rsp_tag_o});
      last_hs_cyc = cyc;
    end
    dn = unit_valid_i && infl_v;
    if (rsp_v && rsp_ready_i) rsp_v = 0;
    if (dn) begin
      {rsp_res_m, rsp_st_m} = unit_fn(infl_m.opa, infl_m.opb, infl_m.sqrt);
      rsp_tag_m     = infl_m.tag;
      rsp_v         = 1;
      infl_v        = 0;
      last_done_cyc = cyc;
    end
    if (exp_en) begin
      infl_m = fifo_m.pop_front();
      infl_v = 1;
    end
    acc = v && sz0 < DEPTH;
    if (acc) fifo_m.push_back(r);
    if (unit_en_o) begin
      en_cnt++;
      last_en_cyc = cyc;
      if (!u_busy) begin
        u_busy = 1;
        u_cnt  = $urandom_range(lat_min, lat_max);
        {u_res, u_st} = unit_fn(unit_opa_o, unit_opb_o, unit_sqrt_o);
      end
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
  endtask

  task automatic drain(input int bound);
    bit acc;
    int n;
    n = 0;
    while ((fifo_m.size() != 0 || infl_v || rsp_v || u_busy) && n < bound) begin
      cycle(1'b0, '0, acc);
      n++;
    end
    check("drain_timeout", 80'(n < bound), 80'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   p;
    int   e0;
    int   n;
    req_t r;

    repeat (2) @(negedge clk_i);
    #1;
    check("rst_req_ready", 80'(req_ready_o), 80'(1));
    check("rst_unit_en", 80'(unit_en_o), 80'(0));
    check("rst_rsp_valid", 80'(rsp_valid_o), 80'(0));
    check("rst_busy", 80'(busy_o), 80'(0));
    check("rst_rsp_fields", 80'({rsp_res_o, rsp_status_o, rsp_tag_o}), 80'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // single divide
    gate_mode = 1; rsp_mode = 1; lat_min = 10; lat_max = 10;
    rsp_log.delete();
    e0 = en_cnt;
    r = '{opa: 32'h4040_0000, opb: 32'h3F80_0000, sqrt: 1'b0,
          tag: 4'h5, rnd: 3'h0};
    cycle(1'b1, r, acc);
    p = cyc;
    drain(100);
    check("div_en_count", 80'(en_cnt - e0), 80'(1));
    check("div_en_cycle", 80'(last_en_cyc), 80'(p + 1));
    check("div_rsp_count", 80'(rsp_log.size()), 80'(1));
    check("div_rsp_res", 80'(rsp_log[0][FW+TW-1:TW]), 80'(32'h4040_0000));
    check("div_rsp_tag", 80'(rsp_log[0][TW-1:0]), 80'(4'h5));
    check("div_rsp_cycle", 80'(last_hs_cyc), 80'(last_done_cyc + 1));

    // fill and backpressure
    gate_mode = 0; lat_min = 2; lat_max = 5;
    rsp_log.delete();
    for (int i = 0; i < 4; i++) begin
      r = rand_req();
      r.tag = TW'(i);
      cycle(1'b1, r, acc);
    end
    r = rand_req();
    r.tag = 4'd4;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, r, acc);
      check("full_ready", 80'(req_ready_o), 80'(0));
    end
    gate_mode = 1;
    cycle(1'b1, r, acc);
    check("full_issue", 80'(unit_en_o), 80'(1));
    check("full_no_bypass", 80'(req_ready_o), 80'(0));
    n = 0;
    while (n < 10) begin
      cycle(1'b1, r, acc);
      n++;
      if (req_ready_o) break;
    end
    check("fifth_accepted", 80'(req_ready_o), 80'(1));
    drain(200);
    check("order_count", 80'(rsp_log.size()), 80'(5));
    for (int i = 0; i < 5; i++)
      check("order_tag", 80'(rsp_log[i][TW-1:0]), 80'(i));

    // response stall
    rsp_mode = 0; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_req(), acc);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      cycle(1'b0, '0, acc);
      n++;
    end
    check("stall_first_rsp", 80'(rsp_valid_o), 80'(1));
    e0 = en_cnt;
    idle(20);
    check("stall_no_issue", 80'(en_cnt - e0), 80'(0));
    rsp_mode = 1;
    cycle(1'b0, '0, acc);
    check("stall_issue_at_hs",
          80'({unit_en_o, rsp_valid_o, rsp_ready_i}), 80'(3'b111));
    drain(200);

    // simultaneous push/pop at two entries, across pointer wrap
    gate_mode = 0; lat_min = 1; lat_max = 3;
    cycle(1'b1, rand_req(), acc);
    cycle(1'b1, rand_req(), acc);
    for (int k = 0; k < 6; k++) begin
      gate_mode = 1;
      cycle(1'b1, rand_req(), acc);
      check("pp_issue", 80'({unit_en_o, req_ready_o}), 80'(2'b11));
      gate_mode = 0;
      n = 0;
      while ((infl_v || rsp_v) && n < 30) begin
        cycle(1'b0, '0, acc);
        n++;
      end
      check("pp_ready_at_two", 80'(req_ready_o), 80'(1));
    end
    cycle(1'b1, rand_req(), acc);
    check("pp_ready_at_three", 80'(req_ready_o), 80'(1));
    cycle(1'b1, rand_req(), acc);
    cycle(1'b0, '0, acc);
    check("pp_full_at_four", 80'(req_ready_o), 80'(0));
    gate_mode = 1;
    drain(300);

    // spurious done pulse while idle
    gate_mode = 0;
    force_spur = 1;
    cycle(1'b0, '0, acc);
    force_spur = 0;
    cycle(1'b0, '0, acc);
    check("spur_empty_rsp", 80'({rsp_valid_o, busy_o}), 80'(2'b00));
    cycle(1'b1, rand_req(), acc);
    force_spur = 1;
    cycle(1'b0, '0, acc);
    force_spur = 0;
    cycle(1'b0, '0, acc);
    check("spur_queued_rsp", 80'({rsp_valid_o, req_ready_o}), 80'(2'b01));
    gate_mode = 1;
    drain(100);

    // randomized traffic
    gate_mode = 2; rsp_mode = 2; lat_min = 1; lat_max = 8; spur_en = 1;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 1) == 1, rand_req(), acc);
    spur_en = 0; gate_mode = 1; rsp_mode = 1;
    drain(300);

    // reset while waiting with two queued
    lat_min = 10; lat_max = 10;
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_req(), acc);
    check("pre_rst_busy", 80'({busy_o, rsp_valid_o}), 80'(2'b10));
    rsp_log.delete();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    unit_valid_i = 1'b0;
    unit_ready_i = 1'b1;
    rsp_ready_i = 1'b1;
    #1;
    check("rst_mid_unit_en", 80'(unit_en_o), 80'(0));
    check("rst_mid_rsp_valid", 80'(rsp_valid_o), 80'(0));
    check("rst_mid_req_ready", 80'(req_ready_o), 80'(1));
    check("rst_mid_busy", 80'(busy_o), 80'(0));
    fifo_m.delete();
    infl_v = 0; rsp_v = 0; u_busy = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(30);
    check("post_rst_no_rsp", 80'(rsp_log.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
